// File: rtl/clkswitch_sched_if.sv
// Signal bundle between the CPU clock-switch sequencer and its surroundings:
// software configuration, the slow-access request, switch acknowledges and controls.
interface clkswitch_sched_if;
  logic       cfg_hs_en;
  logic [1:0] cfg_div_sel;
  logic       ls_req;
  logic       hs_selected_in;
  logic       ls_selected_in;
  logic       err_clr;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       ls_grant;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  cfg_hs_en, cfg_div_sel, ls_req, hs_selected_in, ls_selected_in, err_clr,
    output hsclk_sel, cpuclk_div_sel, ls_grant, busy, timeout_err
  );

  modport master (
    output cfg_hs_en, cfg_div_sel, ls_req, hs_selected_in, ls_selected_in, err_clr,
    input  hsclk_sel, cpuclk_div_sel, ls_grant, busy, timeout_err
  );
endinterface

// File: rtl/clkswitch_sched.sv
// CPU clock-switch sequencer: moves the CPU clock between HS and LS sources with
// hysteresis, acknowledge handshakes and a sticky handshake timeout.
module clkswitch_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int LS_HOLD     = 8,
  parameter int HS_MIN      = 4,
  parameter int TMO_W       = 8,
  parameter int TMO_LIMIT   = 200
) (
  input logic              hsclk_in,
  input logic              rst_b,
  clkswitch_sched_if.slave sw
);
  localparam int HOLD_W  = (LS_HOLD > 0) ? $clog2(LS_HOLD + 1) : 1;
  localparam int DWELL_W = (HS_MIN > 0) ? $clog2(HS_MIN + 1) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(LS_HOLD);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(HS_MIN);
  localparam logic [TMO_W-1:0]   TMO_MAX      = TMO_W'(TMO_LIMIT);

  typedef enum logic [1:0] {LS_RUN, TO_HS, HS_RUN, TO_LS} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
  logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [1:0]             div_q, div_d;
  logic                   hsclk_sel_q, hsclk_sel_d;
  logic                   grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   hs_ack, ls_ack, err_set;
  logic [TMO_W-1:0]       tmo_inc;

  assign hs_ack  = hs_sync_q[SYNC_STAGES-1];
  assign ls_ack  = ls_sync_q[SYNC_STAGES-1];
  assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dwell_d   = dwell_q;
    tmo_d     = tmo_q;
    div_d     = div_q;
    err_set   = 1'b0;
    hs_sync_d = {hs_sync_q[SYNC_STAGES-2:0], sw.hs_selected_in};
    ls_sync_d = {ls_sync_q[SYNC_STAGES-2:0], sw.ls_selected_in};

    case (state_q)
      LS_RUN: begin
        if (!sw.cfg_hs_en || sw.ls_req) hold_d = HOLD_RELOAD;
        else if (hold_q != '0)          hold_d = hold_q - HOLD_W'(1);
        if (sw.cfg_hs_en && !sw.ls_req && hold_q == '0 && ls_ack) begin
          state_d = TO_HS;
          div_d   = sw.cfg_div_sel;
          tmo_d   = '0;
        end
      end
      TO_HS: begin
        tmo_d = tmo_inc;
        // Both acks high is an illegal switch state and counts as no ack.
        if (hs_ack && !ls_ack) begin
          state_d = HS_RUN;
          dwell_d = DWELL_RELOAD;
        end else if (sw.ls_req) begin
          state_d = TO_LS;
          tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
          err_set = 1'b1;
          state_d = TO_LS;
          tmo_d   = '0;
        end
      end
      HS_RUN: begin
        if (dwell_q != '0) dwell_d = dwell_q - DWELL_W'(1);
        if (sw.ls_req || (!sw.cfg_hs_en && dwell_q == '0)) begin
          state_d = TO_LS;
          tmo_d   = '0;
        end
      end
      TO_LS: begin
        tmo_d = tmo_inc;
        // On timeout keep waiting: re-requesting HS without an ack could glitch the CPU clock.
        if (ls_ack && !hs_ack) begin
          state_d = LS_RUN;
          hold_d  = HOLD_RELOAD;
        end else if (tmo_q == TMO_MAX) begin
          err_set = 1'b1;
        end
      end
      default: state_d = LS_RUN;
    endcase

    err_d       = err_set | (err_q & ~sw.err_clr);
    hsclk_sel_d = (state_d == TO_HS) || (state_d == HS_RUN);
    grant_d     = (state_d == LS_RUN);
    busy_d      = (state_d == TO_HS) || (state_d == TO_LS);
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= LS_RUN;
      hs_sync_q   <= '0;
      ls_sync_q   <= '0;
      hold_q      <= '0;
      dwell_q     <= '0;
      tmo_q       <= '0;
      div_q       <= 2'b00;
      hsclk_sel_q <= 1'b0;
      grant_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_sync_q   <= hs_sync_d;
      ls_sync_q   <= ls_sync_d;
      hold_q      <= hold_d;
      dwell_q     <= dwell_d;
      tmo_q       <= tmo_d;
      div_q       <= div_d;
      hsclk_sel_q <= hsclk_sel_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign sw.hsclk_sel      = hsclk_sel_q;
  assign sw.cpuclk_div_sel = div_q;
  assign sw.ls_grant       = grant_q;
  assign sw.busy           = busy_q;
  assign sw.timeout_err    = err_q;
endmodule

// File: tb/tb_clkswitch_sched.sv
// Directed bench for clkswitch_sched: a cycle-level behavioural model of the
// switching rules is compared against the DUT every cycle, plus literal checkpoints.
module tb_clkswitch_sched;
  localparam int SYNC_STAGES = 2;
  localparam int LS_HOLD     = 8;
  localparam int HS_MIN      = 4;
  localparam int TMO_W       = 8;
  localparam int TMO_LIMIT   = 200;

  localparam int M_LS = 0, M_TOHS = 1, M_HS = 2, M_TOLS = 3;

  logic clk = 1'b0;
  logic rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  clkswitch_sched_if ifc ();

  clkswitch_sched #(
    .SYNC_STAGES(SYNC_STAGES), .LS_HOLD(LS_HOLD), .HS_MIN(HS_MIN),
    .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT)
  ) dut (
    .hsclk_in(clk),
    .rst_b   (rst_b),
    .sw      (ifc.slave)
  );

  always #5 clk = ~clk;

  // Model: mode, edges spent in the mode, quiet LS edges since last hold trigger,
  // latched divider, sticky error, and the acknowledge delay lines.
  int         m_mode;
  int         m_age;
  int         m_quiet;
  logic [1:0] m_div;
  logic       m_err;
  bit         hs_hist[$];
  bit         ls_hist[$];

  task automatic model_reset();
    m_mode  = M_LS;
    m_age   = 0;
    m_quiet = LS_HOLD;
    m_div   = 2'b00;
    m_err   = 1'b0;
    hs_hist = {};
    ls_hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      hs_hist.push_back(1'b0);
      ls_hist.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit hs_seen, ls_seen, set_err;
    int next_mode;
    hs_seen = hs_hist.pop_front();
    ls_seen = ls_hist.pop_front();
    hs_hist.push_back(ifc.hs_selected_in);
    ls_hist.push_back(ifc.ls_selected_in);
    next_mode = m_mode;
    set_err   = 1'b0;
    case (m_mode)
      M_LS: begin
        if (ifc.cfg_hs_en && !ifc.ls_req && m_quiet >= LS_HOLD && ls_seen) begin
          next_mode = M_TOHS;
          m_div     = ifc.cfg_div_sel;
        end else if (!ifc.cfg_hs_en || ifc.ls_req) m_quiet = 0;
        else if (m_quiet < 1000) m_quiet++;
      end
      M_TOHS: begin
        if (hs_seen && !ls_seen)   next_mode = M_HS;
        else if (ifc.ls_req)       next_mode = M_TOLS;
        else if (m_age >= TMO_LIMIT) begin
          set_err   = 1'b1;
          next_mode = M_TOLS;
        end
      end
      M_HS: begin
        if (ifc.ls_req || (!ifc.cfg_hs_en && m_age >= HS_MIN)) next_mode = M_TOLS;
      end
      default: begin
        if (ls_seen && !hs_seen) begin
          next_mode = M_LS;
          m_quiet   = 0;
        end else if (m_age >= TMO_LIMIT) set_err = 1'b1;
      end
    endcase
    if (set_err)          m_err = 1'b1;
    else if (ifc.err_clr) m_err = 1'b0;
    m_age  = (next_mode == m_mode) ? m_age + 1 : 0;
    m_mode = next_mode;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("hsclk_sel", 32'(ifc.hsclk_sel), 32'(m_mode == M_TOHS || m_mode == M_HS));
    check("ls_grant", 32'(ifc.ls_grant), 32'(m_mode == M_LS));
    check("busy", 32'(ifc.busy), 32'(m_mode == M_TOHS || m_mode == M_TOLS));
    check("cpuclk_div_sel", 32'(ifc.cpuclk_div_sel), 32'(m_div));
    check("timeout_err", 32'(ifc.timeout_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_b) model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs_seen_cnt;
    rst_b              = 1'b0;
    ifc.cfg_hs_en      = 1'b0;
    ifc.cfg_div_sel    = 2'b01;
    ifc.ls_req         = 1'b0;
    ifc.hs_selected_in = 1'b0;
    ifc.ls_selected_in = 1'b1;
    ifc.err_clr        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hsclk_sel", 32'(ifc.hsclk_sel), 0);
    check("rst_div", 32'(ifc.cpuclk_div_sel), 0);
    check("rst_grant", 32'(ifc.ls_grant), 1);
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_err", 32'(ifc.timeout_err), 0);
    rst_b = 1'b1;
    repeat (4) tick();

    // Turbo enabled: hold counts down 8 edges, then request HS on the 9th.
    ifc.cfg_hs_en = 1'b1;
    n = 0;
    while (!ifc.hsclk_sel && n < 50) begin tick(); n++; end
    check("t1_hs_request_latency", n, 9);
    check("t1_div_latched", 32'(ifc.cpuclk_div_sel), 1);
    ifc.hs_selected_in = 1'b1;
    ifc.ls_selected_in = 1'b0;
    n = 0;
    while (ifc.busy && n < 50) begin tick(); n++; end
    check("t1_hs_run_latency", n, SYNC_STAGES + 1);
    check("t1_hs_run_sel", 32'(ifc.hsclk_sel), 1);

    // Divider change in HS_RUN is ignored; one-cycle ls_req at dwell 3 preempts.
    ifc.cfg_div_sel = 2'b00;
    tick();
    ifc.ls_req = 1'b1;
    tick();
    ifc.ls_req = 1'b0;
    check("t2_hs_drop", 32'(ifc.hsclk_sel), 0);
    check("t2_grant_low", 32'(ifc.ls_grant), 0);
    check("t5_div_hold", 32'(ifc.cpuclk_div_sel), 1);
    ifc.hs_selected_in = 1'b0;
    ifc.ls_selected_in = 1'b1;
    n = 0;
    while (!ifc.ls_grant && n < 50) begin tick(); n++; end
    check("t2_grant_latency", n, 3);
    n = 0;
    while (!ifc.hsclk_sel && n < 50) begin tick(); n++; end
    check("t2_hs_reentry", n, 9);
    check("t5_div_new", 32'(ifc.cpuclk_div_sel), 0);

    // Switch stuck with neither ack: TO_HS times out into TO_LS.
    ifc.ls_selected_in = 1'b0;
    n = 0;
    while (!ifc.timeout_err && n < 300) begin tick(); n++; end
    check("t4_timeout_cycles", n, TMO_LIMIT + 1);
    check("t4_sel_low", 32'(ifc.hsclk_sel), 0);
    check("t4_busy_to_ls", 32'(ifc.busy), 1);
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    check("t4_err_cleared", 32'(ifc.timeout_err), 0);
    repeat (TMO_LIMIT - 1) tick();
    check("t4_err_before_retimeout", 32'(ifc.timeout_err), 0);
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    check("t4_set_beats_clear", 32'(ifc.timeout_err), 1);
    check("t4_still_waiting", 32'(ifc.busy), 1);
    ifc.ls_selected_in = 1'b1;
    n = 0;
    while (!ifc.ls_grant && n < 50) begin tick(); n++; end
    check("t4_recover", n, 3);

    // Clustered slow accesses with 5-cycle gaps: never leave LS.
    hs_seen_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      ifc.ls_req = 1'b1;
      repeat (2) begin tick(); if (ifc.hsclk_sel) hs_seen_cnt++; end
      ifc.ls_req = 1'b0;
      repeat (5) begin tick(); if (ifc.hsclk_sel) hs_seen_cnt++; end
    end
    check("t3_no_hs_in_burst", hs_seen_cnt, 0);
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    check("t3_err_clear_in_ls", 32'(ifc.timeout_err), 0);

    // Asynchronous reset in the middle of TO_HS.
    ifc.cfg_div_sel = 2'b11;
    n = 0;
    while (!ifc.hsclk_sel && n < 50) begin tick(); n++; end
    tick();
    check("t6_in_to_hs", 32'(ifc.busy), 1);
    check("t6_div_pre", 32'(ifc.cpuclk_div_sel), 3);
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    check("t6_async_sel", 32'(ifc.hsclk_sel), 0);
    check("t6_async_grant", 32'(ifc.ls_grant), 1);
    check("t6_async_busy", 32'(ifc.busy), 0);
    check("t6_async_div", 32'(ifc.cpuclk_div_sel), 0);
    repeat (2) tick();
    rst_b = 1'b1;
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
